// File: rtl/seq_mac_pkg.sv
// seq_mac shared types and sizing helpers.
// State enum, accumulator width and saturation bounds.
package seq_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ACC,
    OUT
  } mac_state_t;

  function automatic int acc_width(
    input int bits,
    input int guard
  );
    return 2 * bits + guard;
  endfunction

  function automatic longint sat_max(input int bits);
    return (longint'(1) << (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) << (bits - 1));
  endfunction

endpackage

// File: rtl/seq_mac_shift_add.sv
// Unsigned iterative BITSxBITS shift-add multiplier.
// Ports: clk, reset_n, start, ma, mb in; done, prod out.
module seq_mac_shift_add
  import seq_mac_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BITS-1:0]   ma,
  input  logic [BITS-1:0]   mb,
  output logic              done,
  output logic [2*BITS-1:0] prod
);

  localparam int CW = $clog2(BITS);

  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic [BITS:0]   sum;

  // carry of the upper-half add lands in the MSB after the shift
  assign sum = {1'b0, prod[2*BITS-1:BITS]}
             + (a_q[0] ? {1'b0, b_q} : '0);

  assign done = busy && (cnt == CW'(BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      prod <= '0;
    end else if (start) begin
      a_q  <= ma;
      b_q  <= mb;
      cnt  <= '0;
      busy <= 1'b1;
      prod <= '0;
    end else if (busy) begin
      prod <= {sum, prod[BITS-1:1]};
      a_q  <= a_q >> 1;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_mac.sv
// Sequential signed fixed-point MAC (dot product unit).
// Ports: clk, reset_n, in_valid/in_ready, a, b, last,
//   out_valid/out_ready, result, ovf.
//   Macro SEQ_MAC_SATURATE_EN enables result clamping.
module seq_mac
  import seq_mac_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int FRAC_BITS  = 8,
  parameter int GUARD_BITS = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] result,
  output logic            ovf
);

  localparam int ACC_W = acc_width(BITS, GUARD_BITS);

  mac_state_t state;
  mac_state_t state_d;

  logic                    start;
  logic                    done;
  logic [BITS-1:0]         a_abs;
  logic [BITS-1:0]         b_abs;
  logic [2*BITS-1:0]       prod;
  logic                    sign_q;
  logic                    last_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] ext;
  logic [BITS-1:0]         result_q;
  logic                    ovf_q;
  logic [BITS-1:0]         res_fmt;
  logic                    ovf_fmt;

  assign start     = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign result    = result_q;
  assign ovf       = ovf_q;

  // -2^(BITS-1) maps to 2^(BITS-1) as an unsigned value
  assign a_abs = a[BITS-1] ? (~a + 1'b1) : a;
  assign b_abs = b[BITS-1] ? (~b + 1'b1) : b;

  seq_mac_shift_add #(
    .BITS (BITS)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .ma      (a_abs),
    .mb      (b_abs),
    .done    (done),
    .prod    (prod)
  );

  always_comb begin
    ext   = ACC_W'({{GUARD_BITS{1'b0}}, prod});
    acc_d = sign_q ? (acc_q - ext) : (acc_q + ext);
  end

`ifdef SEQ_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    ACC_W'(sat_max(BITS));
  localparam logic signed [ACC_W-1:0] SMIN =
    ACC_W'(sat_min(BITS));

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_d >>> FRAC_BITS;
    res_fmt = shifted[BITS-1:0];
    ovf_fmt = 1'b0;
    if (shifted > SMAX) begin
      res_fmt = BITS'(SMAX);
      ovf_fmt = 1'b1;
    end else if (shifted < SMIN) begin
      res_fmt = BITS'(SMIN);
      ovf_fmt = 1'b1;
    end
  end
`else
  always_comb begin
    res_fmt = acc_d[FRAC_BITS +: BITS];
    ovf_fmt = 1'b0;
  end
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (in_valid) state_d = MULT;
      MULT: if (done) state_d = ACC;
      ACC:  state_d = last_q ? OUT : IDLE;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      last_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        sign_q <= a[BITS-1] ^ b[BITS-1];
        last_q <= last;
      end
      if (state == ACC) begin
        acc_q <= acc_d;
        if (last_q) begin
          result_q <= res_fmt;
          ovf_q    <= ovf_fmt;
        end
      end
      if (state == OUT && out_ready) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_mac.sv
// Directed self-checking bench for seq_mac.
// BITS=16, FRAC_BITS=8; honours SEQ_MAC_SATURATE_EN.
module tb_seq_mac;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        ovf;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int pulses = 0;
  logic ov_prev = 1'b0;

  seq_mac #(
    .BITS       (16),
    .FRAC_BITS  (8),
    .GUARD_BITS (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !ov_prev) pulses = pulses + 1;
    ov_prev = out_valid;
  end

  task automatic send(
    input  logic [15:0] va,
    input  logic [15:0] vb,
    input  logic        vl,
    output int          acc_cyc
  );
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    a = va;
    b = vb;
    last = vl;
    in_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int seen_cyc);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    seen_cyc = cyc;
    nvec++;
    if (!out_valid) begin
      nerr++;
      $display("FAIL out_timeout out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL consume in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic check_res(
    input string       name,
    input logic [15:0] wr,
    input logic        wo
  );
    nvec++;
    if (result !== wr || ovf !== wo) begin
      nerr++;
      $display("FAIL %s result=%h ovf=%b want %h %b",
               name, result, ovf, wr, wo);
    end
  endtask

  task automatic one(
    input string       name,
    input logic [15:0] va,
    input logic [15:0] vb,
    input logic [15:0] wr,
    input logic        wo
  );
    int ac, oc;
    send(va, vb, 1'b1, ac);
    wait_out(oc);
    check_res(name, wr, wo);
    consume();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    nvec++;
    if (out_valid !== 1'b0 || result !== 16'h0 ||
        ovf !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset ov=%b res=%h ovf=%b rdy=%b want 0 0000 0 1",
               out_valid, result, ovf, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    int ac, oc;
    send(16'h0180, 16'h0200, 1'b1, ac);
    wait_out(oc);
    check_res("single", 16'h0300, 1'b0);
    nvec++;
    if (oc - ac !== 18) begin
      nerr++;
      $display("FAIL latency got=%0d want 18", oc - ac);
    end
    consume();
  endtask

  task automatic test_sign;
    one("sign_neg", 16'hFE80, 16'h0200, 16'hFD00, 1'b0);
    one("sign_both", 16'hFE80, 16'hFE00, 16'h0300, 1'b0);
  endtask

  task automatic test_dot3;
    int ac, oc, p0;
    p0 = pulses;
    send(16'h0100, 16'h0100, 1'b0, ac);
    send(16'h0200, 16'hFF80, 1'b0, ac);
    send(16'h0040, 16'h0400, 1'b1, ac);
    wait_out(oc);
    check_res("dot3", 16'h0100, 1'b0);
    consume();
    repeat (40) @(negedge clk);
    nvec++;
    if (pulses - p0 !== 1) begin
      nerr++;
      $display("FAIL dot3_pulses got=%0d want 1", pulses - p0);
    end
  endtask

  task automatic test_overflow;
`ifdef SEQ_MAC_SATURATE_EN
    one("ovf_pos", 16'h6400, 16'h6400, 16'h7FFF, 1'b1);
    one("ovf_min", 16'h8000, 16'hFF00, 16'h7FFF, 1'b1);
`else
    one("ovf_pos", 16'h6400, 16'h6400, 16'h1000, 1'b0);
    one("ovf_min", 16'h8000, 16'hFF00, 16'h8000, 1'b0);
`endif
  endtask

  task automatic test_backpressure;
    int ac, oc, bad;
    send(16'h0180, 16'h0200, 1'b1, ac);
    wait_out(oc);
    a = 16'h7000;
    b = 16'h7000;
    last = 1'b1;
    in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (result !== 16'h0300 || in_ready !== 1'b0 ||
          out_valid !== 1'b1)
        bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL backpressure bad_cycles=%0d want 0", bad);
    end
    in_valid = 1'b0;
    consume();
    one("bp_next", 16'h0100, 16'h0100, 16'h0100, 1'b0);
  endtask

  task automatic test_reset_mid;
    int ac, oc;
    send(16'h0100, 16'h0200, 1'b1, ac);
    repeat (6) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || result !== 16'h0 ||
        in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid ov=%b res=%h rdy=%b want 0 0000 1",
               out_valid, result, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    one("after_rst", 16'h0100, 16'h0100, 16'h0100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign();
    test_dot3();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
